// File: rtl/se_txn_driver.sv
// se_txn_driver: queues SE transactions, issues them one at a time over the
// SE in/out ready-valid interface, and reports each result with its latency.
// Optional compile-time feature SE_DRV_STALL_EN adds stall_cycles, which holds
// se_out_ready low for a programmable number of WAIT cycles.

package se_txn_driver_pkg;
  localparam int unsigned INST_W = 8;
  localparam int unsigned DATA_W = 128;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] op2;
    logic [DATA_W-1:0] cond;
  } se_txn_t;
endpackage

module se_txn_driver
  import se_txn_driver_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned LAT_W   = 16,
  parameter int unsigned TIMEOUT = 1000
) (
  input  logic              clock,
  input  logic              reset,
`ifdef SE_DRV_STALL_EN
  input  logic [7:0]        stall_cycles,
`endif
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [INST_W-1:0] cmd_inst,
  input  logic [DATA_W-1:0] cmd_op1,
  input  logic [DATA_W-1:0] cmd_op2,
  input  logic [DATA_W-1:0] cmd_cond,
  input  logic              start,
  output logic [INST_W-1:0] se_in_inst,
  output logic [DATA_W-1:0] se_in_op1,
  output logic [DATA_W-1:0] se_in_op2,
  output logic [DATA_W-1:0] se_in_cond,
  output logic              se_in_valid,
  input  logic              se_in_ready,
  input  logic [DATA_W-1:0] se_out_result,
  input  logic              se_out_valid,
  output logic              se_out_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_result,
  output logic [LAT_W-1:0]  rsp_latency,
  output logic              busy,
  output logic              timeout_err,
  output logic [7:0]        done_cnt
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [LAT_W-1:0] LAT_LIMIT = LAT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_e;

  state_e            state_q, state_d;
  se_txn_t           mem_q [DEPTH];
  se_txn_t           head;
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q;
  logic [LAT_W-1:0]  lat_q, lat_d, lat_inc;
  logic              push, pop, in_hs, out_hs, empty, stall_done;
  logic              rsp_fire, timeout_set;
  logic              rsp_valid_q, timeout_err_q;
  logic [DATA_W-1:0] rsp_result_q;
  logic [LAT_W-1:0]  rsp_latency_q;
  logic [7:0]        done_cnt_q;

  assign empty     = (count_q == '0);
  assign cmd_ready = (count_q != CNT_W'(DEPTH));
  assign push      = cmd_valid & cmd_ready;
  assign head      = mem_q[rd_ptr_q];
  assign lat_inc   = (lat_q == '1) ? lat_q : lat_q + LAT_W'(1);

  // SE request side: head of queue falls through, zeroed outside ISSUE
  assign se_in_valid = (state_q == ST_ISSUE);
  assign se_in_inst  = se_in_valid ? head.inst : '0;
  assign se_in_op1   = se_in_valid ? head.op1  : '0;
  assign se_in_op2   = se_in_valid ? head.op2  : '0;
  assign se_in_cond  = se_in_valid ? head.cond : '0;
  assign se_out_ready = (state_q == ST_WAIT) & stall_done;

  assign in_hs  = se_in_valid & se_in_ready;
  assign out_hs = se_out_valid & se_out_ready;

`ifdef SE_DRV_STALL_EN
  logic [7:0] stall_q;
  assign stall_done = (stall_q == 8'd0);

  // Stall countdown: loaded at WAIT entry, drained one per WAIT cycle
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_q <= 8'd0;
    end else if ((state_q == ST_ISSUE) && in_hs) begin
      stall_q <= stall_cycles;
    end else if ((state_q == ST_WAIT) && !stall_done) begin
      stall_q <= stall_q - 8'd1;
    end
  end
`else
  assign stall_done = 1'b1;
`endif

  // Next-state and per-cycle control
  always_comb begin
    state_d     = state_q;
    lat_d       = lat_q;
    pop         = 1'b0;
    rsp_fire    = 1'b0;
    timeout_set = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !empty) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (in_hs) begin
          pop     = 1'b1;
          lat_d   = '0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        lat_d = lat_inc;
        if (out_hs) begin
          rsp_fire = 1'b1;
          state_d  = (!empty || push) ? ST_ISSUE : ST_IDLE;
        end else if (lat_q == LAT_LIMIT) begin
          timeout_set = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, latency counter and queue pointers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      lat_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_q <= count_q + CNT_W'(1);
      else if (pop && !push) count_q <= count_q - CNT_W'(1);
    end
  end

  // Queue storage; contents are don't-care until pushed
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= '{inst: cmd_inst, op1: cmd_op1, op2: cmd_op2, cond: cmd_cond};
  end

  // Response capture, completion count and sticky timeout flag
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rsp_valid_q   <= 1'b0;
      rsp_result_q  <= '0;
      rsp_latency_q <= '0;
      done_cnt_q    <= 8'd0;
      timeout_err_q <= 1'b0;
    end else begin
      rsp_valid_q <= rsp_fire;
      if (rsp_fire) begin
        rsp_result_q  <= se_out_result;
        rsp_latency_q <= lat_inc;
        done_cnt_q    <= done_cnt_q + 8'd1;
      end
      if (timeout_set) timeout_err_q <= 1'b1;
    end
  end

  assign rsp_valid   = rsp_valid_q;
  assign rsp_result  = rsp_result_q;
  assign rsp_latency = rsp_latency_q;
  assign done_cnt    = done_cnt_q;
  assign timeout_err = timeout_err_q;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_se_txn_driver.sv
// Directed bench for se_txn_driver; inputs driven and outputs sampled on negedge.
module tb_se_txn_driver;

  localparam int unsigned DEPTH   = 4;
  localparam int unsigned LAT_W   = 16;
  localparam int unsigned TIMEOUT = 20;

  logic         clock = 1'b0;
  logic         reset;
  logic         cmd_valid, cmd_ready, start;
  logic [7:0]   cmd_inst;
  logic [127:0] cmd_op1, cmd_op2, cmd_cond;
  logic [7:0]   se_in_inst;
  logic [127:0] se_in_op1, se_in_op2, se_in_cond;
  logic         se_in_valid, se_in_ready;
  logic [127:0] se_out_result;
  logic         se_out_valid, se_out_ready;
  logic         rsp_valid;
  logic [127:0] rsp_result;
  logic [LAT_W-1:0] rsp_latency;
  logic         busy, timeout_err;
  logic [7:0]   done_cnt;
`ifdef SE_DRV_STALL_EN
  logic [7:0]   stall_cycles;
`endif

  int checks = 0;
  int errors = 0;
  int exp_done = 0;

  always #5 clock = ~clock;

  se_txn_driver #(.DEPTH(DEPTH), .LAT_W(LAT_W), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset),
`ifdef SE_DRV_STALL_EN
    .stall_cycles(stall_cycles),
`endif
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_inst(cmd_inst),
    .cmd_op1(cmd_op1), .cmd_op2(cmd_op2), .cmd_cond(cmd_cond), .start(start),
    .se_in_inst(se_in_inst), .se_in_op1(se_in_op1), .se_in_op2(se_in_op2),
    .se_in_cond(se_in_cond), .se_in_valid(se_in_valid), .se_in_ready(se_in_ready),
    .se_out_result(se_out_result), .se_out_valid(se_out_valid), .se_out_ready(se_out_ready),
    .rsp_valid(rsp_valid), .rsp_result(rsp_result), .rsp_latency(rsp_latency),
    .busy(busy), .timeout_err(timeout_err), .done_cnt(done_cnt)
  );

  task automatic push(input logic [7:0] i, input logic [127:0] a, input logic [127:0] b,
                      input logic [127:0] c);
    cmd_valid = 1'b1; cmd_inst = i; cmd_op1 = a; cmd_op2 = b; cmd_cond = c;
    @(negedge clock);
    cmd_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  // Called while the DUT is in ISSUE with se_in_ready=1: output handshake lands k cycles later
  task automatic respond(input int k, input logic [127:0] res);
    repeat (k) @(negedge clock);
    se_out_valid = 1'b1; se_out_result = res;
    @(negedge clock);
    se_out_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(negedge clock);
    push(8'h01, 128'd1, 128'd1, 128'd0);
    push(8'h02, 128'd2, 128'd2, 128'd0);
    reset = 1'b0;
    #1;
    checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_cmd_ready: got %0b want 1", cmd_ready); end
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0b want 0", busy); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %0b want 0", rsp_valid); end
    checks++; if (done_cnt !== 8'd0) begin errors++; $display("FAIL rst_done_cnt: got %0d want 0", done_cnt); end
    checks++; if (se_in_valid !== 1'b0) begin errors++; $display("FAIL rst_se_in_valid: got %0b want 0", se_in_valid); end
    checks++; if (se_in_inst !== 8'd0 || se_in_op1 !== 128'd0) begin errors++; $display("FAIL rst_se_in_data: got inst %0h op1 %0h want 0", se_in_inst, se_in_op1); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL rst_timeout_err: got %0b want 0", timeout_err); end
    pulse_start();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_queue_empty: busy %0b want 0", busy); end
  endtask

  task automatic test_single();
    push(8'h05, 128'd3, 128'd4, 128'd0);
    se_in_ready = 1'b1;
    pulse_start();
    checks++; if (se_in_valid !== 1'b1 || se_in_inst !== 8'h05 || se_in_op1 !== 128'd3 || se_in_op2 !== 128'd4)
      begin errors++; $display("FAIL single_issue: valid %0b inst %0h op1 %0h op2 %0h want 1/05/3/4", se_in_valid, se_in_inst, se_in_op1, se_in_op2); end
    respond(3, 128'd7);
    exp_done++;
    checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL single_rsp_valid: got %0b want 1", rsp_valid); end
    checks++; if (rsp_result !== 128'd7) begin errors++; $display("FAIL single_result: got %0h want 7", rsp_result); end
    checks++; if (rsp_latency !== 16'd3) begin errors++; $display("FAIL single_latency: got %0d want 3", rsp_latency); end
    checks++; if (done_cnt !== 8'(exp_done)) begin errors++; $display("FAIL single_done_cnt: got %0d want %0d", done_cnt, exp_done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy: got %0b want 0", busy); end
    @(negedge clock);
    checks++; if (rsp_valid !== 1'b0 || rsp_result !== 128'd7) begin errors++; $display("FAIL single_hold: valid %0b result %0h want 0/7", rsp_valid, rsp_result); end
  endtask

  task automatic test_full();
    for (int i = 0; i < 4; i++) push(8'(8'h10 + i), 128'(100 + i), 128'(200 + i), 128'(i));
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL full_cmd_ready: got %0b want 0", cmd_ready); end
    push(8'hEE, 128'd999, 128'd999, 128'd0);
    checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL full_drop_ready: got %0b want 0", cmd_ready); end
    se_in_ready = 1'b1;
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      checks++; if (se_in_valid !== 1'b1 || se_in_inst !== 8'(8'h10 + i) || se_in_op1 !== 128'(100 + i))
        begin errors++; $display("FAIL full_order_%0d: valid %0b inst %0h op1 %0d want 1/%0h/%0d", i, se_in_valid, se_in_inst, se_in_op1, 8'h10 + i, 100 + i); end
      respond(2, 128'(32'h1000 + i));
      exp_done++;
      checks++; if (rsp_valid !== 1'b1 || rsp_result !== 128'(32'h1000 + i) || rsp_latency !== 16'd2)
        begin errors++; $display("FAIL full_rsp_%0d: valid %0b result %0h lat %0d want 1/%0h/2", i, rsp_valid, rsp_result, rsp_latency, 32'h1000 + i); end
    end
    checks++; if (done_cnt !== 8'(exp_done)) begin errors++; $display("FAIL full_done_cnt: got %0d want %0d", done_cnt, exp_done); end
    checks++; if (busy !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL full_drained: busy %0b ready %0b want 0/1", busy, cmd_ready); end
    @(negedge clock);
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL full_extra_rsp: got %0b want 0", rsp_valid); end
    pulse_start();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL full_fifth_dropped: busy %0b want 0", busy); end
  endtask

  task automatic test_backpressure();
    push(8'hA1, 128'h11, 128'h22, 128'h33);
    se_in_ready = 1'b0;
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      checks++; if (se_in_valid !== 1'b1 || se_in_inst !== 8'hA1 || se_in_op1 !== 128'h11 || se_in_cond !== 128'h33)
        begin errors++; $display("FAIL bp_hold_%0d: valid %0b inst %0h op1 %0h cond %0h want 1/a1/11/33", i, se_in_valid, se_in_inst, se_in_op1, se_in_cond); end
      @(negedge clock);
    end
    se_in_ready = 1'b1;
    respond(2, 128'hBEEF);
    exp_done++;
    checks++; if (rsp_valid !== 1'b1 || rsp_latency !== 16'd2 || rsp_result !== 128'hBEEF)
      begin errors++; $display("FAIL bp_rsp: valid %0b lat %0d result %0h want 1/2/beef", rsp_valid, rsp_latency, rsp_result); end
  endtask

  task automatic test_back_to_back();
    push(8'hB1, 128'd1, 128'd2, 128'd0);
    se_in_ready = 1'b1;
    pulse_start();
    @(negedge clock);
    se_out_valid = 1'b1; se_out_result = 128'hB1;
    cmd_valid = 1'b1; cmd_inst = 8'hB2; cmd_op1 = 128'd5; cmd_op2 = 128'd6; cmd_cond = 128'd0;
    @(negedge clock);
    se_out_valid = 1'b0; cmd_valid = 1'b0;
    exp_done++;
    checks++; if (rsp_valid !== 1'b1 || rsp_latency !== 16'd1 || rsp_result !== 128'hB1)
      begin errors++; $display("FAIL b2b_min_latency: valid %0b lat %0d result %0h want 1/1/b1", rsp_valid, rsp_latency, rsp_result); end
    checks++; if (busy !== 1'b1 || se_in_valid !== 1'b1 || se_in_inst !== 8'hB2)
      begin errors++; $display("FAIL b2b_reissue: busy %0b valid %0b inst %0h want 1/1/b2", busy, se_in_valid, se_in_inst); end
    respond(1, 128'hB2);
    exp_done++;
    checks++; if (rsp_valid !== 1'b1 || rsp_result !== 128'hB2 || done_cnt !== 8'(exp_done))
      begin errors++; $display("FAIL b2b_second: valid %0b result %0h done %0d want 1/b2/%0d", rsp_valid, rsp_result, done_cnt, exp_done); end
  endtask

  task automatic test_timeout();
    int seen_rsp;
    seen_rsp = 0;
    push(8'h71, 128'd7, 128'd1, 128'd0);
    push(8'h72, 128'd8, 128'd2, 128'd0);
    se_in_ready = 1'b1;
    pulse_start();
    repeat (TIMEOUT) begin
      @(negedge clock);
      if (rsp_valid) seen_rsp++;
    end
    checks++; if (busy !== 1'b1 || timeout_err !== 1'b0) begin errors++; $display("FAIL to_early: busy %0b err %0b want 1/0", busy, timeout_err); end
    @(negedge clock);
    if (rsp_valid) seen_rsp++;
    checks++; if (busy !== 1'b0 || timeout_err !== 1'b1) begin errors++; $display("FAIL to_abort: busy %0b err %0b want 0/1", busy, timeout_err); end
    checks++; if (seen_rsp !== 0 || done_cnt !== 8'(exp_done)) begin errors++; $display("FAIL to_no_rsp: rsp pulses %0d done %0d want 0/%0d", seen_rsp, done_cnt, exp_done); end
    @(negedge clock);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL to_stays_idle: busy %0b want 0", busy); end
    pulse_start();
    checks++; if (se_in_valid !== 1'b1 || se_in_inst !== 8'h72) begin errors++; $display("FAIL to_queue_kept: valid %0b inst %0h want 1/72", se_in_valid, se_in_inst); end
    respond(4, 128'h72);
    exp_done++;
    checks++; if (rsp_valid !== 1'b1 || rsp_latency !== 16'd4 || timeout_err !== 1'b1)
      begin errors++; $display("FAIL to_recover: valid %0b lat %0d err %0b want 1/4/1", rsp_valid, rsp_latency, timeout_err); end
  endtask

`ifdef SE_DRV_STALL_EN
  task automatic test_stall();
    push(8'h91, 128'd9, 128'd9, 128'd0);
    stall_cycles = 8'd4;
    se_in_ready = 1'b1;
    pulse_start();
    @(negedge clock);
    stall_cycles = 8'd0;
    se_out_valid = 1'b1; se_out_result = 128'h55;
    for (int j = 0; j < 4; j++) begin
      checks++; if (se_out_ready !== 1'b0) begin errors++; $display("FAIL stall_ready_%0d: got %0b want 0", j, se_out_ready); end
      @(negedge clock);
    end
    checks++; if (se_out_ready !== 1'b1) begin errors++; $display("FAIL stall_release: got %0b want 1", se_out_ready); end
    @(negedge clock);
    se_out_valid = 1'b0;
    exp_done++;
    checks++; if (rsp_valid !== 1'b1 || rsp_latency !== 16'd5 || rsp_result !== 128'h55)
      begin errors++; $display("FAIL stall_latency: valid %0b lat %0d result %0h want 1/5/55", rsp_valid, rsp_latency, rsp_result); end
  endtask
`endif

  task automatic test_mid_reset();
    push(8'h81, 128'd1, 128'd1, 128'd0);
    se_in_ready = 1'b1;
    pulse_start();
    @(negedge clock);
    se_out_valid = 1'b1; se_out_result = 128'h81;
    reset = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || se_out_ready !== 1'b0 || rsp_valid !== 1'b0)
      begin errors++; $display("FAIL mid_rst_async: busy %0b out_ready %0b rsp %0b want 0/0/0", busy, se_out_ready, rsp_valid); end
    checks++; if (done_cnt !== 8'd0 || timeout_err !== 1'b0 || cmd_ready !== 1'b1)
      begin errors++; $display("FAIL mid_rst_regs: done %0d err %0b ready %0b want 0/0/1", done_cnt, timeout_err, cmd_ready); end
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    se_out_valid = 1'b0;
    checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || rsp_result !== 128'd0)
      begin errors++; $display("FAIL mid_rst_discard: rsp %0b busy %0b result %0h want 0/0/0", rsp_valid, busy, rsp_result); end
  endtask

  initial begin
    reset = 1'b0; cmd_valid = 1'b0; cmd_inst = '0; cmd_op1 = '0; cmd_op2 = '0; cmd_cond = '0;
    start = 1'b0; se_in_ready = 1'b0; se_out_valid = 1'b0; se_out_result = '0;
`ifdef SE_DRV_STALL_EN
    stall_cycles = 8'd0;
`endif
    repeat (3) @(negedge clock);
    test_reset();
    test_single();
    test_full();
    test_backpressure();
    test_back_to_back();
    test_timeout();
`ifdef SE_DRV_STALL_EN
    test_stall();
`endif
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
